// File: rtl/n64_bus_router.sv
// n64_bus_router: routes one upstream request at a time to one of NUM_DEVICES
// downstream devices, waits for that device's completion, and answers
// upstream with a single-cycle ack. Requests to unmapped or disabled devices,
// and requests the device never answers, complete with all-ones read data.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | request issued downstream, waiting on the target's dev_ack
// RESP  | ack pulse upstream, rdata valid
module n64_bus_router #(
  parameter int NUM_DEVICES    = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ID_WIDTH      = $clog2(NUM_DEVICES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req,
  input  logic                              write,
  input  logic [ID_WIDTH-1:0]               id,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic                              ack,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              busy,
  input  logic [NUM_DEVICES-1:0]            dev_enable,
  output logic [NUM_DEVICES-1:0]            dev_request,
  output logic                              dev_write,
  output logic [ADDR_WIDTH-1:0]             dev_address,
  output logic [DATA_WIDTH-1:0]             dev_wdata,
  input  logic [NUM_DEVICES-1:0]            dev_ack,
  input  logic [NUM_DEVICES*DATA_WIDTH-1:0] dev_rdata,
  output logic                              err_timeout,
  output logic                              err_overrun,
  input  logic                              err_clear
);

  localparam logic [DATA_WIDTH-1:0] UNMAPPED_DATA = '1;
  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int                 CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ID_WIDTH-1:0]     lid;
  logic [CNT_W-1:0]        cnt;
  logic                    mapped;
  logic                    tgt_ack;
  logic [DATA_WIDTH-1:0]   tgt_rdata;
  logic                    ack_hit;
  logic                    timeout_hit;

  // Select the incoming id's enable bit and the latched target's ack/data.
  // Ids beyond NUM_DEVICES match nothing, so they read as disabled.
  always_comb begin
    mapped    = 1'b0;
    tgt_ack   = 1'b0;
    tgt_rdata = UNMAPPED_DATA;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (id == ID_WIDTH'(i)) begin
        mapped = dev_enable[i];
      end
      if (lid == ID_WIDTH'(i)) begin
        tgt_ack   = dev_ack[i];
        tgt_rdata = dev_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ack takes priority over a timeout landing in the same cycle.
  assign ack_hit     = (state == WAIT) && tgt_ack;
  assign timeout_hit = (state == WAIT) && !tgt_ack && (cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = mapped ? WAIT : RESP;
      WAIT: if (ack_hit || timeout_hit) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = 1'b0;
    ack  = 1'b0;
    case (state)
      WAIT:    busy = 1'b1;
      RESP: begin
        busy = 1'b1;
        ack  = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latching, downstream strobe, timeout counter and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lid         <= '0;
      cnt         <= '0;
      dev_request <= '0;
      dev_write   <= 1'b0;
      dev_address <= '0;
      dev_wdata   <= '0;
      rdata       <= '0;
    end else begin
      dev_request <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            lid         <= id;
            cnt         <= '0;
            dev_write   <= write;
            dev_address <= address;
            dev_wdata   <= wdata;
            if (mapped) dev_request <= NUM_DEVICES'(1) << id;
            else        rdata       <= UNMAPPED_DATA;
          end
        end
        WAIT: begin
          if (ack_hit)          rdata <= dev_write ? UNMAPPED_DATA : tgt_rdata;
          else if (timeout_hit) rdata <= UNMAPPED_DATA;
          else                  cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as err_clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_timeout <= timeout_hit | (err_timeout & ~err_clear);
      err_overrun <= (req && (state != IDLE)) | (err_overrun & ~err_clear);
    end
  end

endmodule

// File: doc/n64_bus_router.md
N64_BUS_ROUTER -- requirements
Module: n64_bus_router

Interface
REQ-001 SHALL have parameter NUM_DEVICES, default 4, number of downstream devices (legal 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of data paths.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, width of address paths.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before forced completion (legal 1..65535).
REQ-005 SHALL define localparam ID_WIDTH = $clog2(NUM_DEVICES), and SHALL define UNMAPPED_DATA as all ones, DATA_WIDTH bits.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-007 req  in  1  upstream request strobe.
REQ-008 write  in  1  1 = write, 0 = read.
REQ-009 id  in  ID_WIDTH  target device index.
REQ-010 address  in  ADDR_WIDTH  request address.
REQ-011 wdata  in  DATA_WIDTH  write data.
REQ-012 ack  out  1  one-cycle completion pulse.
REQ-013 rdata  out  DATA_WIDTH  read data, valid while ack=1.
REQ-014 busy  out  1  transaction in flight.
REQ-015 dev_enable  in  NUM_DEVICES  per-device enable mask.
REQ-016 dev_request  out  NUM_DEVICES  one-hot request pulse.
REQ-017 dev_write / dev_address / dev_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  shared registered copies of the request.
REQ-018 dev_ack  in  NUM_DEVICES  per-device completion.
REQ-019 dev_rdata  in  NUM_DEVICES*DATA_WIDTH  device i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-020 err_timeout / err_overrun  out  1 / 1  sticky error flags; err_clear  in  1  clears both flags.

Function
REQ-021 SHALL implement states IDLE, WAIT, RESP; busy SHALL be 1 in WAIT and RESP.
REQ-022 In IDLE with req=1: SHALL latch write, id, address, wdata into dev_* registers.
REQ-023 Mapped request (id < NUM_DEVICES and dev_enable[id]=1): SHALL pulse dev_request[id] for exactly the next cycle, go to WAIT, and load the timeout counter with 0.
REQ-024 Unmapped request (id >= NUM_DEVICES or device disabled): SHALL NOT assert any dev_request bit, SHALL go to RESP with rdata = UNMAPPED_DATA, and SHALL set no error flag; write data is discarded.
REQ-025 In WAIT: SHALL sample only dev_ack[latched id], including in the dev_request cycle; other dev_ack bits SHALL be ignored.
REQ-026 On dev_ack[id]=1: SHALL capture rdata (dev_rdata slice for reads, UNMAPPED_DATA for writes) and go to RESP.
REQ-027 WAIT SHALL increment the counter each cycle without ack; when the counter reaches TIMEOUT_CYCLES, SHALL go to RESP with rdata = UNMAPPED_DATA and set err_timeout.
REQ-028 Simultaneous ack and timeout: ack SHALL win and no error SHALL be set.
REQ-029 RESP SHALL assert ack for exactly one cycle, then return to IDLE; rdata SHALL hold its value until the next capture.
REQ-030 Latency: mapped request at cycle T with dev_ack at cycle A >= T+1 SHALL give ack at A+1; unmapped request at T SHALL give ack at T+1.
REQ-031 req=1 in WAIT or RESP SHALL be ignored and SHALL set err_overrun.
REQ-032 A late dev_ack arriving in IDLE after a timeout SHALL be ignored.
REQ-033 Error flags SHALL stay set until err_clear=1; if err_clear and a set event occur in the same cycle, set SHALL win.
REQ-034 dev_enable changes during WAIT SHALL NOT abort the transaction in flight.

Reset
REQ-035 Reset SHALL act asynchronously, forcing IDLE, counter 0, and ack, busy, dev_request, dev_write, err_timeout, err_overrun to 0, and rdata, dev_address, dev_wdata to 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction without an ack pulse; dev_ack seen after reset release SHALL be ignored.

Verification
REQ-037 Read of id=1 (enabled), address 0x1000_0000, device returns 0xBEEF with dev_ack 3 cycles after dev_request -> dev_request=0b0010 for exactly 1 cycle, ack 1 cycle after dev_ack with rdata=0xBEEF, no errors.
REQ-038 Request to id=2 with dev_enable[2]=0 -> no dev_request, ack at T+1 with rdata=0xFFFF, no error flags.
REQ-039 TIMEOUT_CYCLES=8, device never acks -> ack at the cycle after the counter reaches 8, rdata=0xFFFF, err_timeout=1; a late dev_ack is ignored and err_clear returns err_timeout to 0.
REQ-040 Second req pulse during WAIT -> no second dev_request, first transaction completes normally, err_overrun=1.
REQ-041 dev_ack coinciding with the timeout cycle, device data 0x1234 -> rdata=0x1234, err_timeout stays 0.
REQ-042 Reset pulsed during WAIT, then dev_ack -> no ack, busy=0, next request handled normally.
